// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD converter arbiter:
//   ANCHO_BIN / ANCHO_BCD : binary operand and 5-digit BCD result widths
//   estado_t              : arbiter state encoding
//   operando_t            : magnitude plus sign of a request operand
//   a_magnitud()          : two's-complement to magnitude/sign conversion
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int ANCHO_BIN = 16;
    localparam int ANCHO_BCD = 20;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        INICIO   = 2'd1,
        ESPERA   = 2'd2,
        RESP     = 2'd3
    } estado_t;

    typedef struct packed {
        logic                 negativo;
        logic [ANCHO_BIN-1:0] magnitud;
    } operando_t;

    // 0x8000 maps to 32768, which still fits the unsigned 16-bit magnitude.
    // Zero has its sign bit clear, so it can never come out negative.
    function automatic operando_t a_magnitud(input logic [ANCHO_BIN-1:0] dato,
                                             input logic                 con_signo);
        operando_t op;
        if (con_signo && dato[ANCHO_BIN-1]) begin
            op.negativo = 1'b1;
            op.magnitud = (~dato) + 16'd1;
        end else begin
            op.negativo = 1'b0;
            op.magnitud = dato;
        end
        return op;
    endfunction

endpackage

// File: rtl/arbitro_rr.sv
// ---------------------------------------------------------------------------
// arbitro_rr
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo N_REQ.
//   i_req       : pending request vector
//   i_puntero   : index with highest priority this round (< N_REQ)
//   o_concesion : one-hot grant (all zero when nothing pending)
//   o_indice    : index of the granted request
//   o_hay       : at least one request pending
// ---------------------------------------------------------------------------
module arbitro_rr #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [1:0]       i_puntero,
    output logic [N_REQ-1:0] o_concesion,
    output logic [1:0]       o_indice,
    output logic             o_hay
);

    always_comb begin
        o_concesion = '0;
        o_indice    = '0;
        o_hay       = 1'b0;
        // Scan from the farthest position back to the pointer so the hit
        // nearest the pointer is the one left standing.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[(int'(i_puntero) + k) % N_REQ]) begin
                o_hay    = 1'b1;
                o_indice = 2'((int'(i_puntero) + k) % N_REQ);
            end
        end
        if (o_hay) begin
            o_concesion = N_REQ'(1) << o_indice;
        end
    end

endmodule

// File: rtl/bcd_arbiter.sv
// ---------------------------------------------------------------------------
// bcd_arbiter
// Shares one binary-to-BCD converter between N_REQ requesters, round-robin.
//   req_valido/req_dato     : requests (held until req_acept), 16 bits each
//   req_acept               : one-cycle grant pulse
//   resp_valido/resp_id     : one-cycle result pulse and responding index
//   resp_bcd/resp_negativo  : BCD magnitude and sign, held to next response
//   resp_error              : last response was a converter timeout
//   bcd_iniciar/bcd_binario : start pulse and operand towards the converter
//   bcd_salida/bcd_terminado: converter result and done flag
// ---------------------------------------------------------------------------
module bcd_arbiter
    import bcd_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter bit CON_SIGNO      = 1'b1,
    parameter int TIMEOUT_CICLOS = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valido,
    input  logic [ANCHO_BIN*N_REQ-1:0] req_dato,
    output logic [N_REQ-1:0]           req_acept,
    output logic [N_REQ-1:0]           resp_valido,
    output logic [1:0]                 resp_id,
    output logic [ANCHO_BCD-1:0]       resp_bcd,
    output logic                       resp_negativo,
    output logic                       resp_error,
    output logic                       bcd_iniciar,
    output logic [ANCHO_BIN-1:0]       bcd_binario,
    input  logic [ANCHO_BCD-1:0]       bcd_salida,
    input  logic                       bcd_terminado
);

    localparam int CNT_W = $clog2(TIMEOUT_CICLOS + 1);

    estado_t              r_estado;
    logic [1:0]           r_puntero;
    logic [1:0]           r_id;
    logic                 r_neg;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_term_prev;
    logic [N_REQ-1:0]     r_req_acept;
    logic [N_REQ-1:0]     r_resp_valido;
    logic [1:0]           r_resp_id;
    logic [ANCHO_BCD-1:0] r_resp_bcd;
    logic                 r_resp_neg;
    logic                 r_resp_err;
    logic                 r_iniciar;
    logic [ANCHO_BIN-1:0] r_binario;

    logic [N_REQ-1:0]     w_concesion;
    logic [1:0]           w_indice;
    logic                 w_hay;
    logic [ANCHO_BIN-1:0] w_dato;
    operando_t            w_op;
    logic                 w_flanco;

    arbitro_rr #(.N_REQ(N_REQ)) u_arbitro (
        .i_req       (req_valido),
        .i_puntero   (r_puntero),
        .o_concesion (w_concesion),
        .o_indice    (w_indice),
        .o_hay       (w_hay)
    );

    assign w_dato   = req_dato[int'(w_indice)*ANCHO_BIN +: ANCHO_BIN];
    assign w_op     = a_magnitud(w_dato, CON_SIGNO);
    // Only a fresh rising edge counts, so a done level left over from an
    // earlier conversion cannot complete the current one.
    assign w_flanco = bcd_terminado & ~r_term_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado      <= INACTIVO;
            r_puntero     <= '0;
            r_id          <= '0;
            r_neg         <= 1'b0;
            r_cnt         <= '0;
            r_term_prev   <= 1'b0;
            r_req_acept   <= '0;
            r_resp_valido <= '0;
            r_resp_id     <= '0;
            r_resp_bcd    <= '0;
            r_resp_neg    <= 1'b0;
            r_resp_err    <= 1'b0;
            r_iniciar     <= 1'b0;
            r_binario     <= '0;
        end else begin
            r_term_prev   <= bcd_terminado;
            r_req_acept   <= '0;
            r_iniciar     <= 1'b0;
            r_resp_valido <= '0;
            case (r_estado)
                INACTIVO: begin
                    // Grant and start pulses are set here so they are
                    // visible for exactly the INICIO cycle.
                    if (w_hay) begin
                        r_id        <= w_indice;
                        r_neg       <= w_op.negativo;
                        r_binario   <= w_op.magnitud;
                        r_req_acept <= w_concesion;
                        r_iniciar   <= 1'b1;
                        r_estado    <= INICIO;
                    end
                end
                INICIO: begin
                    r_puntero <= (r_id == 2'(N_REQ - 1)) ? 2'd0 : r_id + 2'd1;
                    r_cnt     <= '0;
                    r_estado  <= ESPERA;
                end
                ESPERA: begin
                    if (w_flanco) begin
                        r_resp_valido <= N_REQ'(1) << r_id;
                        r_resp_id     <= r_id;
                        r_resp_bcd    <= bcd_salida;
                        r_resp_neg    <= r_neg;
                        r_resp_err    <= 1'b0;
                        r_estado      <= RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CICLOS - 1)) begin
                        // This is the last allowed waiting cycle.
                        r_resp_valido <= N_REQ'(1) << r_id;
                        r_resp_id     <= r_id;
                        r_resp_bcd    <= '0;
                        r_resp_neg    <= 1'b0;
                        r_resp_err    <= 1'b1;
                        r_estado      <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_estado <= INACTIVO;
                end
                default: begin
                    r_estado <= INACTIVO;
                end
            endcase
        end
    end

    assign req_acept     = r_req_acept;
    assign resp_valido   = r_resp_valido;
    assign resp_id       = r_resp_id;
    assign resp_bcd      = r_resp_bcd;
    assign resp_negativo = r_resp_neg;
    assign resp_error    = r_resp_err;
    assign bcd_iniciar   = r_iniciar;
    assign bcd_binario   = r_binario;

endmodule

// File: tb/tb_bcd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bcd_arbiter
// Scoreboard bench: dut_a (signed, 2 requesters) and dut_b (unsigned), each
// with a behavioural converter model.
// ---------------------------------------------------------------------------
module tb_bcd_arbiter;

    localparam int NR = 2;

    typedef struct {
        int          id;
        logic [19:0] bcd;
        logic        neg;
        logic        err;
    } esperado_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut_a signals
    logic [NR-1:0]    a_req = '0;
    logic [16*NR-1:0] a_dato = '0;
    logic [NR-1:0]    a_acept, a_rv;
    logic [1:0]       a_rid;
    logic [19:0]      a_rbcd;
    logic             a_rneg, a_rerr, a_ini;
    logic [15:0]      a_bin;
    logic [19:0]      a_sal = '0;
    logic             a_term = 1'b0;

    // dut_b signals
    logic [NR-1:0]    b_req = '0;
    logic [16*NR-1:0] b_dato = '0;
    logic [NR-1:0]    b_acept, b_rv;
    logic [1:0]       b_rid;
    logic [19:0]      b_rbcd;
    logic             b_rneg, b_rerr, b_ini;
    logic [15:0]      b_bin;
    logic [19:0]      b_sal = '0;
    logic             b_term = 1'b0;

    bcd_arbiter #(.N_REQ(NR), .CON_SIGNO(1'b1), .TIMEOUT_CICLOS(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valido(a_req), .req_dato(a_dato),
        .req_acept(a_acept), .resp_valido(a_rv), .resp_id(a_rid),
        .resp_bcd(a_rbcd), .resp_negativo(a_rneg), .resp_error(a_rerr),
        .bcd_iniciar(a_ini), .bcd_binario(a_bin), .bcd_salida(a_sal),
        .bcd_terminado(a_term)
    );

    bcd_arbiter #(.N_REQ(NR), .CON_SIGNO(1'b0), .TIMEOUT_CICLOS(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valido(b_req), .req_dato(b_dato),
        .req_acept(b_acept), .resp_valido(b_rv), .resp_id(b_rid),
        .resp_bcd(b_rbcd), .resp_negativo(b_rneg), .resp_error(b_rerr),
        .bcd_iniciar(b_ini), .bcd_binario(b_bin), .bcd_salida(b_sal),
        .bcd_terminado(b_term)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [19:0] bin2bcd(input logic [15:0] v);
        logic [19:0] r;
        int          x;
        r = '0;
        x = int'(v);
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Converter model for dut_a: done pulse LAT cycles after start, or never.
    int          m_cnt = 0;
    logic [15:0] m_val = '0;
    bit          m_hang = 1'b0;
    always @(posedge clk) begin
        a_term <= 1'b0;
        if (a_ini) begin
            m_cnt <= 10;
            m_val <= a_bin;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !m_hang) begin
                a_term <= 1'b1;
                a_sal  <= bin2bcd(m_val);
            end
        end
    end

    // Converter model for dut_b: 3-cycle latency.
    int          mb_cnt = 0;
    logic [15:0] mb_val = '0;
    always @(posedge clk) begin
        b_term <= 1'b0;
        if (b_ini) begin
            mb_cnt <= 3;
            mb_val <= b_bin;
        end else if (mb_cnt != 0) begin
            mb_cnt <= mb_cnt - 1;
            if (mb_cnt == 1) begin
                b_term <= 1'b1;
                b_sal  <= bin2bcd(mb_val);
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    esperado_t   sb[$];
    int          g_order[$];
    logic [15:0] exp_mag[NR];
    int          last_resp_cyc = 0;
    int          n_resp = 0;
    logic        term_prev = 1'b0;

    // Response monitor for dut_a
    initial begin
        esperado_t e;
        forever begin
            @(negedge clk);
            if (rst_n && a_rv != '0) begin
                n_resp++;
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 64'(a_rv), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_valido", 64'(a_rv), 64'(NR'(1) << e.id));
                    chk("resp_id", 64'(a_rid), 64'(e.id));
                    chk("resp_bcd", 64'(a_rbcd), 64'(e.bcd));
                    chk("resp_negativo", 64'(a_rneg), 64'(e.neg));
                    chk("resp_error", 64'(a_rerr), 64'(e.err));
                    if (!e.err) chk("resp_after_edge", 64'(term_prev), 64'd1);
                end
                last_resp_cyc = cyc;
            end
            term_prev = a_term;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_req = '0;
        b_req = '0;
        #1;
        chk("reset_outs_a", 64'({a_acept, a_rv, a_rid, a_rbcd, a_rneg, a_rerr, a_ini, a_bin}), 64'd0);
        chk("reset_outs_b", 64'({b_acept, b_rv, b_rid, b_rbcd, b_rneg, b_rerr, b_ini, b_bin}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [15:0] d, input logic [15:0] mag);
        a_dato[i*16 +: 16] = d;
        exp_mag[i] = mag;
    endtask

    task automatic push(input int id, input logic [19:0] bcd, input logic neg, input logic err);
        esperado_t e;
        e.id = id; e.bcd = bcd; e.neg = neg; e.err = err;
        sb.push_back(e);
    endtask

    // Waits for n grants on dut_a, recording order; drops each granted
    // request unless hold is set (then all are dropped after the last).
    task automatic serve(input int n, input bit hold);
        int got = 0;
        int lim = 0;
        while (got < n && lim < 2000) begin
            @(negedge clk);
            lim++;
            for (int i = 0; i < NR; i++) begin
                if (a_acept[i]) begin
                    chk("iniciar_with_acept", 64'(a_ini), 64'd1);
                    chk("bcd_binario", 64'(a_bin), 64'(exp_mag[i]));
                    chk("grant_spacing", 64'((cyc - last_resp_cyc) >= 2), 64'd1);
                    g_order.push_back(i);
                    got++;
                    if (!hold) a_req[i] = 1'b0;
                end
            end
        end
        if (got < n) chk("acept_timeout", 64'(got), 64'(n));
        if (hold) a_req = '0;
    endtask

    task automatic drain();
        int lim = 0;
        while (sb.size() != 0 && lim < 400) begin
            @(negedge clk);
            lim++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k;
        int n0;

        // Test 1: single request, exact handshake timing
        do_reset();
        set_req(0, 16'd255, 16'd255);
        push(0, 20'h00255, 1'b0, 1'b0);
        @(posedge clk); #1;
        a_req = 2'b01;
        @(negedge clk);
        chk("t1_acept_not_yet", 64'(a_acept), 64'd0);
        @(negedge clk);
        chk("t1_acept", 64'(a_acept), 64'd1);
        chk("t1_iniciar", 64'(a_ini), 64'd1);
        chk("t1_binario", 64'(a_bin), 64'd255);
        a_req = '0;
        @(negedge clk);
        chk("t1_acept_pulse", 64'(a_acept), 64'd0);
        chk("t1_iniciar_pulse", 64'(a_ini), 64'd0);
        chk("t1_binario_held", 64'(a_bin), 64'd255);
        drain();
        chk("t1_binario_after_resp", 64'(a_bin), 64'd255);

        // Test 2: simultaneous requests after reset, requester 0 first
        do_reset();
        set_req(0, 16'd1234, 16'd1234);
        set_req(1, 16'hFFD6, 16'd42);
        push(0, 20'h01234, 1'b0, 1'b0);
        push(1, 20'h00042, 1'b1, 1'b0);
        g_order.delete();
        @(posedge clk); #1;
        a_req = 2'b11;
        serve(2, 1'b0);
        chk("t2_first", 64'(g_order[0]), 64'd0);
        chk("t2_second", 64'(g_order[1]), 64'd1);
        drain();

        // Test 3: both held for six conversions, strict alternation
        set_req(0, 16'd7, 16'd7);
        set_req(1, 16'hFFFF, 16'd1);
        for (int i = 0; i < 6; i++) push(i % 2, (i % 2) ? 20'h00001 : 20'h00007, 1'(i % 2), 1'b0);
        g_order.delete();
        @(posedge clk); #1;
        a_req = 2'b11;
        serve(6, 1'b1);
        for (int i = 0; i < 6; i++) chk("t3_order", 64'(g_order[i]), 64'(i % 2));
        drain();

        // Test 4: sign boundaries, signed and unsigned instances
        set_req(0, 16'h8000, 16'h8000);
        push(0, 20'h32768, 1'b1, 1'b0);
        @(posedge clk); #1;
        a_req = 2'b01;
        serve(1, 1'b0);
        drain();
        set_req(1, 16'h0000, 16'h0000);
        push(1, 20'h00000, 1'b0, 1'b0);
        @(posedge clk); #1;
        a_req = 2'b10;
        serve(1, 1'b0);
        drain();
        b_dato[16 +: 16] = 16'hFFFF;
        @(posedge clk); #1;
        b_req = 2'b10;
        k = 0;
        while (b_acept == '0 && k < 50) begin @(negedge clk); k++; end
        chk("t4_b_acept", 64'(b_acept), 64'h2);
        chk("t4_b_binario", 64'(b_bin), 64'hFFFF);
        b_req = '0;
        k = 0;
        while (b_rv == '0 && k < 50) begin @(negedge clk); k++; end
        chk("t4_b_resp_valido", 64'(b_rv), 64'h2);
        chk("t4_b_resp_id", 64'(b_rid), 64'd1);
        chk("t4_b_resp_bcd", 64'(b_rbcd), 64'h65535);
        chk("t4_b_resp_neg", 64'(b_rneg), 64'd0);
        chk("t4_b_resp_err", 64'(b_rerr), 64'd0);

        // Test 5: hung converter, timeout after 64 waiting cycles
        m_hang = 1'b1;
        set_req(0, 16'hFFFB, 16'd5);
        push(0, 20'h00000, 1'b0, 1'b1);
        @(posedge clk); #1;
        a_req = 2'b01;
        serve(1, 1'b0);
        k = 0;
        do begin @(negedge clk); k++; end while (a_rv == '0 && k < 200);
        chk("t5_timeout_cycles", 64'(k), 64'd65);
        drain();
        m_hang = 1'b0;
        set_req(1, 16'd99, 16'd99);
        push(1, 20'h00099, 1'b0, 1'b0);
        @(posedge clk); #1;
        a_req = 2'b10;
        serve(1, 1'b0);
        drain();
        chk("t5_error_cleared", 64'(a_rerr), 64'd0);

        // Test 6: reset in the middle of a conversion
        set_req(0, 16'd321, 16'd321);
        @(posedge clk); #1;
        a_req = 2'b01;
        serve(1, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_outs_in_reset", 64'({a_acept, a_rv, a_rid, a_rbcd, a_rneg, a_rerr, a_ini, a_bin}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n0 = n_resp;
        repeat (20) @(negedge clk);
        chk("t6_no_resp", 64'(n_resp - n0), 64'd0);
        chk("t6_outs_idle", 64'({a_acept, a_rv, a_rid, a_rbcd, a_rneg, a_rerr, a_ini, a_bin}), 64'd0);
        set_req(0, 16'd500, 16'd500);
        push(0, 20'h00500, 1'b0, 1'b0);
        @(posedge clk); #1;
        a_req = 2'b01;
        serve(1, 1'b0);
        drain();

        chk("final_queue", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
